// File: rtl/dcache_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dcache_ctrl
// Purpose  : Direct-mapped, write-back, write-allocate data cache between the
//            CPU MEM stage and a multi-cycle, 128-bit line-wide main memory.
//            Hits complete with no stall; misses stall the pipeline while
//            the FSM writes back a dirty victim and refills the line.
// Options  : DCACHE_STATS_EN - adds hit_cnt_o / miss_cnt_o access counters.
// Revision : 1.0 - initial release
// ============================================================================
module dcache_ctrl #(
  parameter int LINES = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         cpu_req_i,
  input  logic         cpu_we_i,
  input  logic [31:0]  cpu_addr_i,
  input  logic [31:0]  cpu_wdata_i,
  output logic [31:0]  cpu_rdata_o,
  output logic         cpu_stall_o,
  output logic         mem_req_o,
  output logic         mem_we_o,
  output logic [31:0]  mem_addr_o,
  output logic [127:0] mem_wdata_o,
  input  logic [127:0] mem_rdata_i,
  input  logic         mem_ack_i
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]  hit_cnt_o,
  output logic [31:0]  miss_cnt_o
`endif
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = 28 - IDX_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WB    = 2'd1,
    ALLOC = 2'd2
  } state_e;

  state_e state_q, state_d;

  // Line storage: valid/dirty are reset, tag and data are not.
  logic [LINES-1:0] valid_q;
  logic [LINES-1:0] dirty_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [127:0]     line_q [LINES];

  // Line address ({tag, idx}) captured when the miss is detected, so the
  // write-back and refill finish on the right line even if the CPU drops
  // its request mid-miss.
  logic [27:0] miss_line_q;

  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  logic [1:0]       req_off;
  logic [IDX_W-1:0] miss_idx;
  logic [TAG_W-1:0] miss_tag;
  logic             hit;
  logic             store_hit;
  logic             miss_start;
  logic             wb_done;
  logic             refill_done;
  logic             unused_addr;

  assign req_idx  = cpu_addr_i[4+IDX_W-1:4];
  assign req_tag  = cpu_addr_i[31:4+IDX_W];
  assign req_off  = cpu_addr_i[3:2];
  assign miss_idx = miss_line_q[IDX_W-1:0];
  assign miss_tag = miss_line_q[27:IDX_W];

  // Byte lane bits are not used by a word-addressed cache.
  assign unused_addr = ^cpu_addr_i[1:0];

  assign hit         = valid_q[req_idx] & (tag_q[req_idx] == req_tag);
  assign store_hit   = (state_q == IDLE) & cpu_req_i & cpu_we_i & hit;
  assign miss_start  = (state_q == IDLE) & cpu_req_i & ~hit;
  assign wb_done     = (state_q == WB) & mem_ack_i;
  assign refill_done = (state_q == ALLOC) & mem_ack_i;

  assign cpu_stall_o = cpu_req_i & ((state_q != IDLE) | ~hit);
  assign cpu_rdata_o = line_q[req_idx][{req_off, 5'b00000} +: 32];
  assign mem_wdata_o = line_q[miss_idx];

  // Miss FSM state register; reset aborts any outstanding memory request.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and memory port decode.
  always_comb begin
    state_d    = state_q;
    mem_req_o  = 1'b0;
    mem_we_o   = 1'b0;
    mem_addr_o = 32'h0;
    case (state_q)
      IDLE: begin
        if (miss_start) begin
          state_d = (valid_q[req_idx] & dirty_q[req_idx]) ? WB : ALLOC;
        end
      end
      WB: begin
        mem_req_o  = 1'b1;
        mem_we_o   = 1'b1;
        mem_addr_o = {tag_q[miss_idx], miss_idx, 4'b0000};
        if (mem_ack_i) begin
          state_d = ALLOC;
        end
      end
      ALLOC: begin
        mem_req_o  = 1'b1;
        mem_addr_o = {miss_line_q, 4'b0000};
        if (mem_ack_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Line status bits and the captured miss address.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q     <= '0;
      dirty_q     <= '0;
      miss_line_q <= '0;
    end else begin
      if (miss_start) begin
        miss_line_q <= cpu_addr_i[31:4];
      end
      if (store_hit) begin
        dirty_q[req_idx] <= 1'b1;
      end
      if (wb_done) begin
        dirty_q[miss_idx] <= 1'b0;
      end
      if (refill_done) begin
        valid_q[miss_idx] <= 1'b1;
        dirty_q[miss_idx] <= 1'b0;
      end
    end
  end

  // Tag and data arrays: refill writes a whole line, a store hit one word.
  always_ff @(posedge clk_i) begin
    if (refill_done) begin
      line_q[miss_idx] <= mem_rdata_i;
      tag_q[miss_idx]  <= miss_tag;
    end
    if (store_hit) begin
      line_q[req_idx][{req_off, 5'b00000} +: 32] <= cpu_wdata_i;
    end
  end

`ifdef DCACHE_STATS_EN
  logic        retry_q;
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;

  // Access counters; the hit that retires a refilled miss is not a hit.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      retry_q    <= 1'b0;
      hit_cnt_q  <= 32'h0;
      miss_cnt_q <= 32'h0;
    end else begin
      retry_q <= refill_done;
      if ((state_q == IDLE) & cpu_req_i & hit & ~retry_q) begin
        hit_cnt_q <= hit_cnt_q + 32'd1;
      end
      if (miss_start) begin
        miss_cnt_q <= miss_cnt_q + 32'd1;
      end
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`else
  // Statistics counters are not built.
`endif

endmodule
`default_nettype wire

// File: tb/tb_dcache_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dcache_ctrl
// Purpose  : Self-checking bench for dcache_ctrl with a latency-programmable
//            line memory model and a scoreboard of expected load data.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dcache_ctrl;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         cpu_req_i;
  logic         cpu_we_i;
  logic [31:0]  cpu_addr_i;
  logic [31:0]  cpu_wdata_i;
  logic [31:0]  cpu_rdata_o;
  logic         cpu_stall_o;
  logic         mem_req_o;
  logic         mem_we_o;
  logic [31:0]  mem_addr_o;
  logic [127:0] mem_wdata_o;
  logic [127:0] mem_rdata_i;
  logic         mem_ack_i;
`ifdef DCACHE_STATS_EN
  logic [31:0]  hit_cnt_o;
  logic [31:0]  miss_cnt_o;
`endif

  dcache_ctrl #(.LINES(16)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .cpu_req_i   (cpu_req_i),
    .cpu_we_i    (cpu_we_i),
    .cpu_addr_i  (cpu_addr_i),
    .cpu_wdata_i (cpu_wdata_i),
    .cpu_rdata_o (cpu_rdata_o),
    .cpu_stall_o (cpu_stall_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i),
    .mem_ack_i   (mem_ack_i)
`ifdef DCACHE_STATS_EN
    ,
    .hit_cnt_o   (hit_cnt_o),
    .miss_cnt_o  (miss_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic         we;
    logic [31:0]  addr;
    logic [127:0] wdata;
  } txn_t;

  int           n_checks = 0;
  int           n_pass   = 0;
  int           ack_lat  = 1;
  txn_t         obs_q[$];
  logic [31:0]  exp_q[$];
  logic [127:0] mem_m [logic [31:0]];

  // Line memory: acks in the ack_lat-th cycle of a request, logs every
  // completed transaction.
  initial begin
    int   cnt;
    txn_t t;
    cnt         = 0;
    mem_ack_i   = 1'b0;
    mem_rdata_i = '0;
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        cnt       = 0;
        mem_ack_i = 1'b0;
      end else begin
        if (mem_ack_i) begin
          mem_ack_i = 1'b0;
          cnt       = 0;
        end
        if (mem_req_o) begin
          cnt++;
          if (cnt >= ack_lat) begin
            t.we    = mem_we_o;
            t.addr  = mem_addr_o;
            t.wdata = mem_wdata_o;
            obs_q.push_back(t);
            if (mem_we_o) mem_m[mem_addr_o] = mem_wdata_o;
            else mem_rdata_i = mem_m.exists(mem_addr_o) ? mem_m[mem_addr_o] : '0;
            mem_ack_i = 1'b1;
          end
        end
      end
    end
  end

  function automatic txn_t next_txn();
    txn_t t;
    if (obs_q.size() > 0) begin
      t = obs_q.pop_front();
    end else begin
      t.we    = 1'bx;
      t.addr  = 'x;
      t.wdata = 'x;
    end
    return t;
  endfunction

  // One CPU access: holds the request until the stall clears, counts stall
  // cycles, returns the load data seen in the completing cycle.
  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        output int stalls, output logic [31:0] rdata, output logic req_seen);
    @(negedge clk_i);
    cpu_req_i   = 1'b1;
    cpu_we_i    = we;
    cpu_addr_i  = addr;
    cpu_wdata_i = wdata;
    #1;
    stalls   = 0;
    req_seen = mem_req_o;
    while (cpu_stall_o !== 1'b0 && stalls < 100) begin
      stalls++;
      @(negedge clk_i);
      #1;
      req_seen = req_seen | mem_req_o;
    end
    rdata = cpu_rdata_o;
    @(posedge clk_i);
    #1;
    cpu_req_i = 1'b0;
    cpu_we_i  = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    #1;
    n_checks++; if (cpu_stall_o !== 1'b0) $display("FAIL reset_stall: got %b expected 0", cpu_stall_o); else n_pass++;
    n_checks++; if (mem_req_o !== 1'b0) $display("FAIL reset_mem_req: got %b expected 0", mem_req_o); else n_pass++;
    n_checks++; if (mem_we_o !== 1'b0) $display("FAIL reset_mem_we: got %b expected 0", mem_we_o); else n_pass++;
`ifdef DCACHE_STATS_EN
    n_checks++; if (hit_cnt_o !== 32'd0) $display("FAIL reset_hit_cnt: got %0d expected 0", hit_cnt_o); else n_pass++;
    n_checks++; if (miss_cnt_o !== 32'd0) $display("FAIL reset_miss_cnt: got %0d expected 0", miss_cnt_o); else n_pass++;
`endif
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  task automatic test_clean_miss();
    int s; logic [31:0] rd, e; logic rs; txn_t t;
    mem_m[32'h40] = {32'h44, 32'h33, 32'h22, 32'h11};
    ack_lat = 3;
    obs_q.delete();
    exp_q.push_back(32'h11);
    access(1'b0, 32'h40, 32'h0, s, rd, rs);
    e = exp_q.pop_front();
    n_checks++; if (s != 4) $display("FAIL clean_miss_stall: got %0d expected 4", s); else n_pass++;
    n_checks++; if (rd !== e) $display("FAIL clean_miss_rdata: got %h expected %h", rd, e); else n_pass++;
    n_checks++; if (obs_q.size() != 1) $display("FAIL clean_miss_txns: got %0d expected 1", obs_q.size()); else n_pass++;
    t = next_txn();
    n_checks++; if (t.addr !== 32'h40) $display("FAIL clean_miss_addr: got %h expected 00000040", t.addr); else n_pass++;
    n_checks++; if (t.we !== 1'b0) $display("FAIL clean_miss_we: got %b expected 0", t.we); else n_pass++;
  endtask

  task automatic test_hit();
    int s; logic [31:0] rd, e; logic rs;
    obs_q.delete();
    exp_q.push_back(32'h33);
    access(1'b0, 32'h48, 32'h0, s, rd, rs);
    e = exp_q.pop_front();
    n_checks++; if (s != 0) $display("FAIL hit_stall: got %0d expected 0", s); else n_pass++;
    n_checks++; if (rd !== e) $display("FAIL hit_rdata: got %h expected %h", rd, e); else n_pass++;
    n_checks++; if (rs !== 1'b0) $display("FAIL hit_mem_req: got %b expected 0", rs); else n_pass++;
    n_checks++; if (obs_q.size() != 0) $display("FAIL hit_txns: got %0d expected 0", obs_q.size()); else n_pass++;
  endtask

  task automatic test_dirty_miss();
    int s; logic [31:0] rd, e; logic rs; txn_t t;
    obs_q.delete();
    access(1'b1, 32'h44, 32'hDEADBEEF, s, rd, rs);
    n_checks++; if (s != 0) $display("FAIL store_hit_stall: got %0d expected 0", s); else n_pass++;
    mem_m[32'h440] = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    ack_lat = 2;
    exp_q.push_back(32'hA1);
    access(1'b0, 32'h444, 32'h0, s, rd, rs);
    e = exp_q.pop_front();
    n_checks++; if (s != 5) $display("FAIL dirty_miss_stall: got %0d expected 5", s); else n_pass++;
    n_checks++; if (rd !== e) $display("FAIL dirty_miss_rdata: got %h expected %h", rd, e); else n_pass++;
    n_checks++; if (obs_q.size() != 2) $display("FAIL dirty_miss_txns: got %0d expected 2", obs_q.size()); else n_pass++;
    t = next_txn();
    n_checks++; if (t.we !== 1'b1) $display("FAIL wb_we: got %b expected 1", t.we); else n_pass++;
    n_checks++; if (t.addr !== 32'h40) $display("FAIL wb_addr: got %h expected 00000040", t.addr); else n_pass++;
    n_checks++; if (t.wdata[63:32] !== 32'hDEADBEEF) $display("FAIL wb_word1: got %h expected deadbeef", t.wdata[63:32]); else n_pass++;
    n_checks++; if (t.wdata !== {32'h44, 32'h33, 32'hDEADBEEF, 32'h11}) $display("FAIL wb_line: got %h expected %h", t.wdata, {32'h44, 32'h33, 32'hDEADBEEF, 32'h11}); else n_pass++;
    t = next_txn();
    n_checks++; if (t.we !== 1'b0) $display("FAIL alloc_we: got %b expected 0", t.we); else n_pass++;
    n_checks++; if (t.addr !== 32'h440) $display("FAIL alloc_addr: got %h expected 00000440", t.addr); else n_pass++;
  endtask

  task automatic test_store_miss();
    int s; logic [31:0] rd, e; logic rs; txn_t t;
    mem_m[32'h80] = {32'hB3, 32'hB2, 32'hB1, 32'hB0};
    ack_lat = 1;
    obs_q.delete();
    access(1'b1, 32'h80, 32'hCAFEF00D, s, rd, rs);
    n_checks++; if (s != 2) $display("FAIL store_miss_stall: got %0d expected 2", s); else n_pass++;
    t = next_txn();
    n_checks++; if (t.we !== 1'b0 || t.addr !== 32'h80) $display("FAIL store_miss_alloc: got we=%b addr=%h expected we=0 addr=00000080", t.we, t.addr); else n_pass++;
    exp_q.push_back(32'hCAFEF00D);
    access(1'b0, 32'h80, 32'h0, s, rd, rs);
    e = exp_q.pop_front();
    n_checks++; if (s != 0) $display("FAIL merged_load_stall: got %0d expected 0", s); else n_pass++;
    n_checks++; if (rd !== e) $display("FAIL merged_load_rdata: got %h expected %h", rd, e); else n_pass++;
    obs_q.delete();
    exp_q.push_back(32'h0);
    access(1'b0, 32'h880, 32'h0, s, rd, rs);
    e = exp_q.pop_front();
    n_checks++; if (s != 3) $display("FAIL conflict_stall: got %0d expected 3", s); else n_pass++;
    n_checks++; if (rd !== e) $display("FAIL conflict_rdata: got %h expected %h", rd, e); else n_pass++;
    t = next_txn();
    n_checks++; if (t.we !== 1'b1 || t.addr !== 32'h80) $display("FAIL conflict_wb: got we=%b addr=%h expected we=1 addr=00000080", t.we, t.addr); else n_pass++;
    n_checks++; if (t.wdata !== {32'hB3, 32'hB2, 32'hB1, 32'hCAFEF00D}) $display("FAIL conflict_wb_line: got %h expected %h", t.wdata, {32'hB3, 32'hB2, 32'hB1, 32'hCAFEF00D}); else n_pass++;
    t = next_txn();
    n_checks++; if (t.we !== 1'b0 || t.addr !== 32'h880) $display("FAIL conflict_alloc: got we=%b addr=%h expected we=0 addr=00000880", t.we, t.addr); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int s; logic [31:0] rd, e; logic rs;
    mem_m[32'h100] = {32'hD3, 32'hD2, 32'hD1, 32'hD0};
    ack_lat = 6;
    obs_q.delete();
    @(negedge clk_i);
    cpu_req_i  = 1'b1;
    cpu_we_i   = 1'b0;
    cpu_addr_i = 32'h100;
    repeat (3) @(negedge clk_i);
    #2;
    n_checks++; if (mem_req_o !== 1'b1 || mem_we_o !== 1'b0) $display("FAIL mid_alloc_req: got req=%b we=%b expected req=1 we=0", mem_req_o, mem_we_o); else n_pass++;
    rst_i = 1'b1;
    #1;
    n_checks++; if (mem_req_o !== 1'b0) $display("FAIL async_reset_req: got %b expected 0", mem_req_o); else n_pass++;
    cpu_req_i = 1'b0;
    @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    n_checks++; if (obs_q.size() != 0) $display("FAIL aborted_txns: got %0d expected 0", obs_q.size()); else n_pass++;
    ack_lat = 2;
    exp_q.push_back(32'hD0);
    access(1'b0, 32'h100, 32'h0, s, rd, rs);
    e = exp_q.pop_front();
    n_checks++; if (s != 3) $display("FAIL re_miss_stall: got %0d expected 3", s); else n_pass++;
    n_checks++; if (rd !== e) $display("FAIL re_miss_rdata: got %h expected %h", rd, e); else n_pass++;
  endtask

`ifdef DCACHE_STATS_EN
  task automatic test_stats();
    int s; logic [31:0] rd; logic rs;
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i   = 1'b0;
    ack_lat = 1;
    access(1'b0, 32'h100, 32'h0, s, rd, rs);
    access(1'b0, 32'h104, 32'h0, s, rd, rs);
    access(1'b0, 32'h108, 32'h0, s, rd, rs);
    access(1'b0, 32'h200, 32'h0, s, rd, rs);
    #1;
    n_checks++; if (hit_cnt_o !== 32'd2) $display("FAIL stats_hits: got %0d expected 2", hit_cnt_o); else n_pass++;
    n_checks++; if (miss_cnt_o !== 32'd2) $display("FAIL stats_misses: got %0d expected 2", miss_cnt_o); else n_pass++;
  endtask
`endif

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed so far", n_pass, n_checks);
    $fatal(1);
  end

  initial begin
    rst_i       = 1'b1;
    cpu_req_i   = 1'b0;
    cpu_we_i    = 1'b0;
    cpu_addr_i  = 32'h0;
    cpu_wdata_i = 32'h0;
    test_reset();
    test_clean_miss();
    test_hit();
    test_dirty_miss();
    test_store_miss();
    test_reset_mid();
`ifdef DCACHE_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
